// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-channel TDM receive path.
// Contents: channel count, slot index type, receiver lock-state enum,
//           and a helper that turns a slot index into a one-hot strobe.
package tdm_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] slot_t;

    typedef enum logic {
        HUNT = 1'b0,
        SYNC = 1'b1
    } state_t;

    function automatic logic [NUM_CH-1:0] slot_onehot(input slot_t s);
        logic [NUM_CH-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/tdm_deser.sv
// W-bit serial-to-parallel shifter with bit counter (MSB first).
// Latency: o_word/o_done are combinational from the bit being accepted this cycle.
// Backpressure: none; the shifter advances only when i_start or i_shift is high.
//
// Ports:
//   clk, rst_n  clock, async active-low reset
//   i_start     load i_bit as bit 0 of a fresh word (bit counter -> 1)
//   i_shift     shift i_bit in as the next bit of the current word
//   i_bit       serial data bit
//   o_cnt       bits already collected for the current word
//   o_done      this shift completes a word
//   o_word      completed word (valid when o_done)
module tdm_deser #(
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_shift,
    input  logic                 i_bit,
    output logic [$clog2(W)-1:0] o_cnt,
    output logic                 o_done,
    output logic [W-1:0]         o_word
);

    localparam int CW = $clog2(W);

    // Only W-1 bits need storing: the last bit is taken straight from i_bit.
    logic [W-2:0] r_sh;
    logic [CW-1:0] r_cnt;

    assign o_word = {r_sh, i_bit};
    assign o_done = i_shift && (r_cnt == CW'(W - 1));
    assign o_cnt  = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_sh    <= '0;
            r_sh[0] <= i_bit;
            r_cnt   <= CW'(1);
        end else if (i_shift) begin
            r_sh  <= o_word[W-2:0];
            r_cnt <= o_done ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: locks to fsync, deserialises slots 0..3 onto d0..d3.
// Latency: word registered on the edge that accepts its last bit; valid strobes one cycle.
// Backpressure: none; din_valid low freezes all state, fsync is ignored while it is low.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   din, din_valid    serial bit and its qualifier
//   fsync             marks the current accepted bit as slot 0 bit 0
//   d0..d3            last completed word per channel
//   valid             one-hot strobe, bit k when dk updated
//   slot              slot index of the next expected bit
//   locked            high in SYNC
//   frame_err         one-cycle pulse on a sync violation
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic              din_valid,
    input  logic              fsync,
    output logic [W-1:0]      d0,
    output logic [W-1:0]      d1,
    output logic [W-1:0]      d2,
    output logic [W-1:0]      d3,
    output logic [NUM_CH-1:0] valid,
    output logic [1:0]        slot,
    output logic              locked,
    output logic              frame_err
);

    localparam int CW = $clog2(W);

    state_t              r_state;
    state_t              w_state_nxt;
    slot_t               r_slot;
    logic [W-1:0]        r_d [NUM_CH];
    logic [NUM_CH-1:0]   r_valid;
    logic                r_err;

    logic                w_start;
    logic                w_shift;
    logic                w_err;
    logic                w_done;
    logic                w_at_start;
    logic [CW-1:0]       w_cnt;
    logic [W-1:0]        w_word;

    tdm_deser #(.W(W)) u_deser (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_shift (w_shift),
        .i_bit   (din),
        .o_cnt   (w_cnt),
        .o_done  (w_done),
        .o_word  (w_word)
    );

    // Position where a frame is expected to begin.
    assign w_at_start = (r_slot == slot_t'(0)) && (w_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift     = 1'b0;
        w_err       = 1'b0;
        if (din_valid) begin
            case (r_state)
                HUNT: begin
                    if (fsync) begin
                        w_start     = 1'b1;
                        w_state_nxt = SYNC;
                    end
                end
                SYNC: begin
                    if (fsync) begin
                        // Early fsync: drop the partial word and restart the frame here.
                        w_start = 1'b1;
                        w_err   = !w_at_start;
                    end else if (w_at_start) begin
                        // Missing fsync: bit discarded, fall back to hunting.
                        w_err       = 1'b1;
                        w_state_nxt = HUNT;
                    end else begin
                        w_shift = 1'b1;
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot  <= '0;
            r_valid <= '0;
            r_err   <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_d[k] <= '0;
            end
        end else begin
            r_err   <= w_err;
            r_valid <= w_done ? slot_onehot(r_slot) : '0;
            if (w_start) begin
                r_slot <= '0;
            end else if (w_done) begin
                r_slot <= r_slot + slot_t'(1);
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_done && (r_slot == slot_t'(k))) begin
                    r_d[k] <= w_word;
                end
            end
        end
    end

    assign d0        = r_d[0];
    assign d1        = r_d[1];
    assign d2        = r_d[2];
    assign d3        = r_d[3];
    assign valid     = r_valid;
    assign slot      = r_slot;
    assign locked    = (r_state == SYNC);
    assign frame_err = r_err;

endmodule
